// File: rtl/dsp_mem_pkg.sv
// dsp_mem_pkg
// Shared types and defaults for the DSP memory bank: write-collision policy,
// controller state encoding and default word/address widths.
package dsp_mem_pkg;

  localparam int DEFAULT_DATA_W = 36;
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } wr_mode_e;

  typedef enum logic {
    CLEAR,
    RUN
  } bank_state_e;

endpackage

// File: rtl/dsp_mem_bank_if.sv
// dsp_mem_bank_if
// Bus bundle for the DSP memory bank.
//   core read  : core_rd_en, core_rd_addr -> core_rd_data, core_rd_valid
//   core write : core_wr_en, core_wr_addr, core_wr_data
//   host load  : host_valid, host_addr, host_data -> host_ready
//   status     : init_done
// master = the client driving requests, slave = the memory bank.
interface dsp_mem_bank_if
  import dsp_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic                     core_rd_en;
  logic [ADDR_W-1:0]        core_rd_addr;
  logic signed [DATA_W-1:0] core_rd_data;
  logic                     core_rd_valid;

  logic                     core_wr_en;
  logic [ADDR_W-1:0]        core_wr_addr;
  logic signed [DATA_W-1:0] core_wr_data;

  logic                     host_valid;
  logic                     host_ready;
  logic [ADDR_W-1:0]        host_addr;
  logic signed [DATA_W-1:0] host_data;

  logic                     init_done;

  modport master (
    output core_rd_en, core_rd_addr, core_wr_en, core_wr_addr, core_wr_data,
           host_valid, host_addr, host_data,
    input  core_rd_data, core_rd_valid, host_ready, init_done
  );

  modport slave (
    input  core_rd_en, core_rd_addr, core_wr_en, core_wr_addr, core_wr_data,
           host_valid, host_addr, host_data,
    output core_rd_data, core_rd_valid, host_ready, init_done
  );

endinterface

// File: rtl/dsp_mem_rd_pipe.sv
// dsp_mem_rd_pipe
// LATENCY-deep delay line for read data and its qualifier.
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/in_data: read request qualifier and the word read this cycle
//   out_valid/out_data: delayed qualifier and held read data
// Only the valid stages are reset, so in-flight reads are dropped on reset.
// The final data register loads only on a valid word and is also cleared,
// so out_data reads 0 after reset and otherwise holds the last word.
module dsp_mem_rd_pipe #(
  parameter int DATA_W  = 36,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0]       valid_q;
  logic signed [DATA_W-1:0] last_in;
  logic                     last_en;
  logic signed [DATA_W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  generate
    if (LATENCY == 1) begin : g_one
      assign last_in = in_data;
      assign last_en = in_valid;
    end else begin : g_multi
      logic signed [DATA_W-1:0] mid_q [LATENCY-1];
      always_ff @(posedge clk) begin
        mid_q[0] <= in_data;
        for (int i = 1; i < LATENCY - 1; i++) mid_q[i] <= mid_q[i-1];
      end
      assign last_in = mid_q[LATENCY-2];
      assign last_en = valid_q[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)        out_q <= '0;
    else if (last_en) out_q <= last_in;
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = out_q;

endmodule

// File: rtl/dsp_mem_bank.sv
// dsp_mem_bank
// Single-port-write / single-port-read coefficient and sample store. After
// reset every word is cleared, then core and host writes are accepted.
//   clk   : system clock
//   reset : synchronous active-high reset, restarts the clear
//   bus   : dsp_mem_bank_if.slave (core read/write, host load, init_done)
//
// state | meaning
// CLEAR | writing 0 to each word, one per cycle; writes dropped, reads give 0
// RUN   | normal operation; core write has priority over host load
module dsp_mem_bank
  import dsp_mem_pkg::*;
#(
  parameter int       DATA_W     = DEFAULT_DATA_W,
  parameter int       ADDR_W     = DEFAULT_ADDR_W,
  parameter int       DEPTH      = 1 << ADDR_W,
  parameter int       RD_LATENCY = 1,
  parameter wr_mode_e WR_MODE    = READ_FIRST
) (
  input logic           clk,
  input logic           reset,
  dsp_mem_bank_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 3 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_param
      $error("dsp_mem_bank: illegal DEPTH/RD_LATENCY");
    end
  endgenerate

  bank_state_e              state, state_nxt;
  logic [ADDR_W-1:0]        clr_cnt, clr_cnt_nxt;
  logic                     init_done_q;
  logic                     host_ready_c;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic signed [DATA_W-1:0] mem_wdata;
  logic signed [DATA_W-1:0] rd_word;

  logic signed [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      init_done_q <= (state == RUN);
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = '0;
    host_ready_c = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN: begin
        host_ready_c = !bus.core_wr_en;
        if (bus.core_wr_en) begin
          mem_we    = in_range(bus.core_wr_addr);
          mem_waddr = bus.core_wr_addr;
          mem_wdata = bus.core_wr_data;
        end else if (bus.host_valid) begin
          mem_we    = in_range(bus.host_addr);
          mem_waddr = bus.host_addr;
          mem_wdata = bus.host_data;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
  end

  // Array read feeds the first pipe register (BRAM output register after
  // flattening). Out-of-range reads and reads during the clear return 0.
  always_comb begin
    rd_word = mem[bus.core_rd_addr[IDX_W-1:0]];
    if (WR_MODE == WRITE_FIRST && mem_we && mem_waddr == bus.core_rd_addr)
      rd_word = mem_wdata;
    if (state == CLEAR || !in_range(bus.core_rd_addr))
      rd_word = '0;
  end

  dsp_mem_rd_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.core_rd_en),
    .in_data   (rd_word),
    .out_valid (bus.core_rd_valid),
    .out_data  (bus.core_rd_data)
  );

  assign bus.host_ready = host_ready_c;
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_dsp_mem_bank.sv
// tb_dsp_mem_bank
// Two banks share one stimulus stream: a 16-word READ_FIRST bank and a
// 12-word WRITE_FIRST bank, both with a 2-cycle read latency. A behavioural
// model pushes expected read words when a read is driven; the checker pops
// them when the data is due and also tracks host_ready, init_done and the
// held read data every cycle.
module tb_dsp_mem_bank;
  import dsp_mem_pkg::*;

  localparam int DW  = 36;
  localparam int AW  = 4;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          rd_en      = 1'b0;
  logic          wr_en      = 1'b0;
  logic          host_valid = 1'b0;
  logic [AW-1:0] rd_addr    = '0;
  logic [AW-1:0] wr_addr    = '0;
  logic [AW-1:0] host_addr  = '0;
  logic [DW-1:0] wr_data    = '0;
  logic [DW-1:0] host_data  = '0;

  dsp_mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  dsp_mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  assign if_a.core_rd_en   = rd_en;      assign if_b.core_rd_en   = rd_en;
  assign if_a.core_rd_addr = rd_addr;    assign if_b.core_rd_addr = rd_addr;
  assign if_a.core_wr_en   = wr_en;      assign if_b.core_wr_en   = wr_en;
  assign if_a.core_wr_addr = wr_addr;    assign if_b.core_wr_addr = wr_addr;
  assign if_a.core_wr_data = wr_data;    assign if_b.core_wr_data = wr_data;
  assign if_a.host_valid   = host_valid; assign if_b.host_valid   = host_valid;
  assign if_a.host_addr    = host_addr;  assign if_b.host_addr    = host_addr;
  assign if_a.host_data    = host_data;  assign if_b.host_data    = host_data;

  dsp_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .RD_LATENCY(LAT), .WR_MODE(READ_FIRST))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  dsp_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .RD_LATENCY(LAT), .WR_MODE(WRITE_FIRST))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  logic          vld  [2];
  logic [DW-1:0] dat  [2];
  logic          rdy  [2];
  logic          done [2];
  assign vld[0]  = if_a.core_rd_valid; assign vld[1]  = if_b.core_rd_valid;
  assign dat[0]  = if_a.core_rd_data;  assign dat[1]  = if_b.core_rd_data;
  assign rdy[0]  = if_a.host_ready;    assign rdy[1]  = if_b.host_ready;
  assign done[0] = if_a.init_done;     assign done[1] = if_b.init_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] mm   [2][16];
  int            cnt  [2] = '{0, 0};
  logic [DW-1:0] last [2] = '{'0, '0};
  string         nm   [2] = '{"rf16", "wf12"};
  int            cyc = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  always @(negedge clk) begin
    exp_t          e;
    exp_t          n;
    logic          has;
    logic [DW-1:0] ed;
    logic [DW-1:0] rv;
    logic [DW-1:0] wd;
    logic          run;
    logic          we;
    int            wa;
    int            ra;

    cyc++;
    has = (sbq.size() > 0) && (sbq[0].due == cyc);
    e = has ? sbq[0] : '{0, '0, '0};
    for (int i = 0; i < 2; i++) begin
      ed = (i == 0) ? e.d0 : e.d1;
      check({nm[i], ".rd_valid"}, 64'(vld[i]), 64'(has));
      if (has && vld[i]) check({nm[i], ".rd_data"}, 64'(dat[i]), 64'(ed));
      if (!vld[i])       check({nm[i], ".rd_hold"}, 64'(dat[i]), 64'(last[i]));
      if (has) last[i] = ed;
      check({nm[i], ".host_ready"}, 64'(rdy[i]), 64'(cnt[i] >= dep(i) && !wr_en));
      check({nm[i], ".init_done"},  64'(done[i]), 64'(cnt[i] > dep(i)));
    end
    if (has) void'(sbq.pop_front());

    if (reset) begin
      sbq.delete();
      for (int i = 0; i < 2; i++) begin
        cnt[i]  = 0;
        last[i] = '0;
        for (int a = 0; a < 16; a++) mm[i][a] = '0;
      end
    end else begin
      n.due = cyc + LAT;
      n.d0  = '0;
      n.d1  = '0;
      ra    = int'(rd_addr);
      for (int i = 0; i < 2; i++) begin
        run = cnt[i] >= dep(i);
        we  = 1'b0;
        wa  = 0;
        wd  = '0;
        if (run && wr_en) begin
          we = 1'b1; wa = int'(wr_addr); wd = wr_data;
        end else if (run && host_valid) begin
          we = 1'b1; wa = int'(host_addr); wd = host_data;
        end
        if (wa >= dep(i)) we = 1'b0;
        if (!run || ra >= dep(i))        rv = '0;
        else if (i == 1 && we && wa == ra) rv = wd;
        else                              rv = mm[i][ra];
        if (i == 0) n.d0 = rv;
        else        n.d1 = rv;
        if (we) mm[i][wa] = wd;
        if (cnt[i] < 1000) cnt[i]++;
      end
      if (rd_en) sbq.push_back(n);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Counts cycles from reset release to init_done on the 16-word bank; a
  // read and a write are issued while the clear is still running.
  task automatic wait_init(input int exp_lat);
    int  seen_at;
    seen_at = 0;
    for (int k = 1; k <= 40 && seen_at == 0; k++) begin
      rd_en = (k == 3);
      rd_addr = 4'd5;
      wr_en = (k == 5);
      wr_addr = 4'd4;
      wr_data = 36'd123;
      step();
      if (if_a.init_done) seen_at = k;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("init_latency", 64'(seen_at), 64'(exp_lat));
  endtask

  initial begin
    logic [63:0] r;
    bit          hs;
    int          w;

    repeat (3) step();
    check("rst.rd_valid",   64'(if_a.core_rd_valid), 64'(0));
    check("rst.rd_data",    64'(if_a.core_rd_data),  64'(0));
    check("rst.host_ready", 64'(if_a.host_ready),    64'(0));
    check("rst.init_done",  64'(if_a.init_done),     64'(0));
    reset = 1'b0;
    wait_init(17);

    do_rd(4'd5);
    do_rd(4'd4);

    do_wr(4'd3, 36'h8_0000_0001);
    do_rd(4'd3);
    rd_en = 1'b1;
    rd_addr = 4'd3; step();
    rd_addr = 4'd5; step();
    rd_addr = 4'd3; step();
    rd_en = 1'b0;
    do_wr(4'd6, 36'hF_FFFF_FFFE);
    do_rd(4'd6);

    // host load stalled by three core writes
    host_valid = 1'b1; host_addr = 4'd7; host_data = 36'd42;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = AW'(9 + k); wr_data = DW'(100 + k);
      @(negedge clk);
      check("host_stall_ready", 64'(if_a.host_ready), 64'(0));
      step();
    end
    wr_en = 1'b0;
    w = 0;
    @(negedge clk);
    while (!if_a.host_ready && w < 10) begin
      step();
      w++;
      @(negedge clk);
    end
    check("host_accept_wait", 64'(w), 64'(0));
    step();
    host_valid = 1'b0;
    do_rd(4'd7);
    do_rd(4'd9);
    do_rd(4'd10);
    do_rd(4'd11);

    // same-address collisions, core then host
    do_wr(4'd2, 36'd10);
    rd_en = 1'b1; rd_addr = 4'd2;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 36'd20;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    do_rd(4'd2);
    host_valid = 1'b1; host_addr = 4'd2; host_data = 36'd30;
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    host_valid = 1'b0; rd_en = 1'b0;
    do_rd(4'd2);

    // addresses beyond the 12-word bank
    do_wr(4'd1, 36'd55);
    do_wr(4'd13, 36'd77);
    do_rd(4'd13);
    do_rd(4'd1);
    do_rd(4'd12);

    // random mixed traffic with a well-behaved host
    hs = 1'b0;
    for (int it = 0; it < 300; it++) begin
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      r = {$urandom(), $urandom()};
      wr_data = r[DW-1:0];
      if (!host_valid || hs) begin
        host_valid = ($urandom_range(0, 2) == 0);
        host_addr  = AW'($urandom_range(0, 15));
        r = {$urandom(), $urandom()};
        host_data  = r[DW-1:0];
      end
      @(negedge clk);
      hs = host_valid && if_a.host_ready;
      step();
    end
    rd_en = 1'b0; wr_en = 1'b0; host_valid = 1'b0;
    repeat (4) step();

    // reset one cycle after a read, then again mid-clear
    do_rd(4'd3);
    reset = 1'b1; step(); reset = 1'b0;
    repeat (8) step();
    reset = 1'b1; step(); reset = 1'b0;
    wait_init(17);
    rd_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      step();
    end
    rd_en = 1'b0;
    repeat (5) step();
    check("sb_drain", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsp_mem_bank.md
DSP_MEM_BANK -- requirements
Module: dsp_mem_bank

Interface
REQ-001 Parameter DATA_W, default 36, sample/parameter word width (signed).
REQ-002 Parameter ADDR_W, default 10, address width.
REQ-003 Parameter DEPTH, default 1<<ADDR_W, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LATENCY, default 1, legal 1..3, read-enable to data cycles.
REQ-005 Parameter WR_MODE, default READ_FIRST, same-address read/write collision policy (READ_FIRST | WRITE_FIRST).
REQ-006 Ports: clk in 1 system clock; reset in 1 synchronous active-high reset; the block has one clock, and reset is synchronous and active-high.
REQ-007 core_rd_en in 1 read request; core_rd_addr in ADDR_W read address.
REQ-008 core_rd_data out DATA_W signed read data; core_rd_valid out 1 read data qualifier.
REQ-009 core_wr_en in 1 write strobe; core_wr_addr in ADDR_W; core_wr_data in DATA_W signed.
REQ-010 host_valid in 1, host_ready out 1, host_addr in ADDR_W, host_data in DATA_W: parameter-load write port, valid/ready handshake.
REQ-011 init_done out 1: high once memory clear has completed.

Function
REQ-012 FSM states CLEAR, RUN; reset enters CLEAR.
REQ-013 CLEAR: writes 0 to address 0..DEPTH-1, one per cycle, with a clear counter; after DEPTH cycles, move to RUN and set init_done=1 on the next cycle.
REQ-014 CLEAR: core writes dropped; host_ready=0; core reads still produce core_rd_valid with data 0.
REQ-015 RUN: core read at cycle N yields core_rd_valid=1 and data at cycle N+RD_LATENCY; one valid pulse per read; back-to-back reads every cycle supported.
REQ-016 core_rd_data holds its last value when core_rd_valid=0.
REQ-017 RUN: core_wr_en=1 writes core_wr_data at core_wr_addr at the clock edge.
REQ-018 host_ready = (state==RUN) & ~core_wr_en, combinational; core write has priority.
REQ-019 Host write is committed only on a cycle with host_valid & host_ready; host SHALL hold addr/data while stalled.
REQ-020 Same-cycle read and write (core or host) to the same address: READ_FIRST returns the old word; WRITE_FIRST returns the new word.
REQ-021 Address >= DEPTH: writes dropped; reads return 0 with normal valid timing.
REQ-022 No arithmetic; data passes bit-exact, sign preserved.

Reset
REQ-023 On reset: core_rd_data=0, core_rd_valid=0, all read-pipe valid stages=0, host_ready=0, init_done=0, clear counter=0, state=CLEAR.
REQ-024 Reset asserted mid-CLEAR or mid-RUN aborts in-flight reads (no valid emitted) and restarts the full clear.

Structure
REQ-025 Package dsp_mem_pkg holds wr_mode_e (READ_FIRST, WRITE_FIRST), state enum, DEFAULT_DATA_W=36, DEFAULT_ADDR_W=10.
REQ-026 Sub-module dsp_mem_rd_pipe: RD_LATENCY-deep data/valid delay line with synchronous reset on valid only.
REQ-027 Storage is inferred block RAM; no reset on the array itself.

Verification (DEPTH=16, ADDR_W=4, RD_LATENCY=2 unless noted)
REQ-028 Reset, wait -> init_done rises 17 cycles after reset deassert; read addr 5 -> valid at +2 with 0.
REQ-029 Write 36'h8_0000_0001 to addr 3, read addr 3 next cycle -> data 36'h8_0000_0001 two cycles later, valid for exactly one cycle.
REQ-030 host_valid=1 addr 7 data 42 with core_wr_en=1 for 3 cycles -> host_ready=0 for 3 cycles, committed on 4th; read addr 7 -> 42.
REQ-031 Addr 2 holds 10; same cycle write 20 and read addr 2 -> READ_FIRST returns 10, WRITE_FIRST returns 20.
REQ-032 DEPTH=12: write addr 13 then read addr 13 -> 0; addr 1 unchanged.
REQ-033 Reset pulsed 1 cycle after a read and during clear at count 8 -> no valid from aborted read; init_done low until 17 cycles after final reset deassert; all words read 0.
